// File: rtl/overlap_add_synth_if.sv
// Sample-stream bundle between the IFFT side and the overlap-add block.
// The master drives frame samples; the slave returns finished samples and errors.
interface overlap_add_synth_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic                     frame_start_i;
  logic                     sample_valid_i;
  logic signed [DATA_W-1:0] sample_i;
  logic                     out_valid_o;
  logic signed [DATA_W-1:0] out_sample_o;
  logic                     frame_err_o;

  modport master (
    output frame_start_i,
    output sample_valid_i,
    output sample_i,
    input  out_valid_o,
    input  out_sample_o,
    input  frame_err_o
  );

  modport slave (
    input  frame_start_i,
    input  sample_valid_i,
    input  sample_i,
    output out_valid_o,
    output out_sample_o,
    output frame_err_o
  );
endinterface

// File: rtl/overlap_add_synth.sv
// Overlap-add resynthesis: folds FFT_SIZE-sample frames into a circular accumulator
// and emits HOP_SIZE saturated samples per frame, one cycle after each accepted sample.
module overlap_add_synth #(
  parameter int unsigned FFT_SIZE = 256,
  parameter int unsigned HOP_SIZE = 128,
  parameter int unsigned DATA_W   = 16
) (
  input logic               clk_i,
  input logic               reset_i,
  overlap_add_synth_if.slave bus
);
  localparam int unsigned ACC_W = DATA_W + $clog2(FFT_SIZE / HOP_SIZE);
  localparam int unsigned AW    = $clog2(FFT_SIZE);

  typedef logic [AW-1:0] addr_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  localparam addr_t HopA  = addr_t'(HOP_SIZE);
  localparam addr_t LastA = addr_t'(FFT_SIZE - 1);
  localparam acc_t  SatMax = {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam acc_t  SatMin = {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

  acc_t                     acc_q [FFT_SIZE];
  acc_t                     acc_d [FFT_SIZE];
  addr_t                    base_q, base_d;
  addr_t                    idx_q, idx_d;
  logic                     in_frame_q, in_frame_d;
  logic                     out_valid_q, out_valid_d;
  logic signed [DATA_W-1:0] out_sample_q, out_sample_d;
  logic                     frame_err_q, frame_err_d;

  logic                     accept, mid_err;
  addr_t                    base_eff, n, addr;
  acc_t                     sum;
  logic signed [DATA_W-1:0] sat;

  assign accept   = bus.sample_valid_i & (bus.frame_start_i | in_frame_q);
  assign mid_err  = bus.sample_valid_i & bus.frame_start_i & in_frame_q & (idx_q != '0);
  // A truncated frame still advances the hop before the new frame is addressed.
  assign base_eff = mid_err ? base_q + HopA : base_q;
  assign n        = bus.frame_start_i ? '0 : idx_q;
  assign addr     = base_eff + n;
  assign sum      = acc_q[addr] + {{(ACC_W - DATA_W){bus.sample_i[DATA_W-1]}}, bus.sample_i};

  always_comb begin
    sat = sum[DATA_W-1:0];
    if (sum > SatMax) begin
      sat = SatMax[DATA_W-1:0];
    end else if (sum < SatMin) begin
      sat = SatMin[DATA_W-1:0];
    end
  end

  always_comb begin
    acc_d        = acc_q;
    base_d       = base_q;
    idx_d        = idx_q;
    in_frame_d   = in_frame_q;
    out_valid_d  = 1'b0;
    out_sample_d = out_sample_q;
    frame_err_d  = 1'b0;
    if (accept) begin
      frame_err_d = mid_err;
      base_d      = base_eff;
      if (n < HopA) begin
        // Finished slot is cleared so the next frame starts it from zero.
        acc_d[addr]  = '0;
        out_valid_d  = 1'b1;
        out_sample_d = sat;
      end else begin
        acc_d[addr] = sum;
      end
      if (n == LastA) begin
        base_d     = base_eff + HopA;
        idx_d      = '0;
        in_frame_d = 1'b0;
      end else begin
        idx_d      = n + addr_t'(1);
        in_frame_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      for (int i = 0; i < int'(FFT_SIZE); i++) begin
        acc_q[i] <= '0;
      end
      base_q       <= '0;
      idx_q        <= '0;
      in_frame_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      frame_err_q  <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      base_q       <= base_d;
      idx_q        <= idx_d;
      in_frame_q   <= in_frame_d;
      out_valid_q  <= out_valid_d;
      out_sample_q <= out_sample_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.out_valid_o  = out_valid_q;
  assign bus.out_sample_o = out_sample_q;
  assign bus.frame_err_o  = frame_err_q;
endmodule

// File: tb/tb_overlap_add_synth.sv
// Bench for overlap_add_synth: a 256/128 instance for frame tables and corner cases,
// and an 8/4 instance for the small hand-computed overlap example.
module tb_overlap_add_synth;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  overlap_add_synth_if #(.DATA_W(16)) if_b ();
  overlap_add_synth_if #(.DATA_W(16)) if_s ();

  overlap_add_synth #(.FFT_SIZE(256), .HOP_SIZE(128), .DATA_W(16)) u_big (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (if_b)
  );

  overlap_add_synth #(.FFT_SIZE(8), .HOP_SIZE(4), .DATA_W(16)) u_small (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (if_s)
  );

  typedef struct {int val; int cyc;} exp_t;
  typedef struct {bit rst; int val; bit gaps; int exp;} vec_t;

  exp_t q_b[$];
  exp_t q_s[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   hold_b = 0;
  int   err_cyc = -1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Big-instance monitor: value, latency, idle hold and error pulse.
  always @(negedge clk) begin
    exp_t e;
    if (if_b.out_valid_o) begin
      if (q_b.size() == 0) begin
        check("big unexpected pulse", 1, 0);
      end else begin
        e = q_b.pop_front();
        check("big sample", int'(if_b.out_sample_o), e.val);
        check("big latency", cyc, e.cyc + 1);
        hold_b = e.val;
      end
    end else begin
      check("big hold", int'(if_b.out_sample_o), hold_b);
    end
    if (if_b.frame_err_o || cyc == err_cyc) begin
      check("big frame_err", int'(if_b.frame_err_o), int'(cyc == err_cyc));
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (if_s.out_valid_o) begin
      if (q_s.size() == 0) begin
        check("small unexpected pulse", 1, 0);
      end else begin
        e = q_s.pop_front();
        check("small sample", int'(if_s.out_sample_o), e.val);
        check("small latency", cyc, e.cyc + 1);
      end
    end
    if (if_s.frame_err_o) check("small frame_err", 1, 0);
  end

  task automatic drv_b(input logic st, input int s);
    @(posedge clk);
    #1;
    if_b.frame_start_i  = st;
    if_b.sample_valid_i = 1'b1;
    if_b.sample_i       = 16'(s);
  endtask

  task automatic idle_b();
    @(posedge clk);
    #1;
    if_b.frame_start_i  = 1'b0;
    if_b.sample_valid_i = 1'b0;
  endtask

  task automatic drv_s(input logic st, input int s);
    @(posedge clk);
    #1;
    if_s.frame_start_i  = st;
    if_s.sample_valid_i = 1'b1;
    if_s.sample_i       = 16'(s);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    if_b.frame_start_i  = 1'b0;
    if_b.sample_valid_i = 1'b0;
    if_s.frame_start_i  = 1'b0;
    if_s.sample_valid_i = 1'b0;
    @(posedge clk);
    #1;
    hold_b = 0;
    @(negedge clk);
    check("reset out_valid", int'(if_b.out_valid_o), 0);
    check("reset out_sample", int'(if_b.out_sample_o), 0);
    check("reset frame_err", int'(if_b.frame_err_o), 0);
    check("reset small out_valid", int'(if_s.out_valid_o), 0);
    rst_n = 1'b1;
  endtask

  task automatic send_frame(input int val, input int exp, input bit gaps, input int len,
                            input bit mid);
    for (int n = 0; n < len; n++) begin
      if (gaps && $urandom_range(0, 2) == 0) idle_b();
      drv_b(n == 0, val);
      if (n == 0 && mid) err_cyc = cyc + 1;
      if (n < 128) q_b.push_back('{exp, cyc});
    end
  endtask

  initial begin
    vec_t tbl[9];
    int   sm_exp[4];
    tbl[0] = '{1'b1, 100, 1'b0, 100};
    tbl[1] = '{1'b0, 100, 1'b0, 200};
    tbl[2] = '{1'b0, 100, 1'b0, 200};
    tbl[3] = '{1'b1, 30000, 1'b0, 30000};
    tbl[4] = '{1'b0, 30000, 1'b0, 32767};
    tbl[5] = '{1'b1, -30000, 1'b0, -30000};
    tbl[6] = '{1'b0, -30000, 1'b0, -32768};
    tbl[7] = '{1'b1, 100, 1'b1, 100};
    tbl[8] = '{1'b0, 100, 1'b1, 200};
    sm_exp = '{14, 16, 18, 20};

    if_b.frame_start_i  = 1'b0;
    if_b.sample_valid_i = 1'b0;
    if_b.sample_i       = '0;
    if_s.frame_start_i  = 1'b0;
    if_s.sample_valid_i = 1'b0;
    if_s.sample_i       = '0;

    for (int i = 0; i < 9; i++) begin
      if (tbl[i].rst) do_reset();
      send_frame(tbl[i].val, tbl[i].exp, tbl[i].gaps, 256, 1'b0);
    end
    repeat (3) idle_b();

    // Restart at n = 50: error pulse, new frame lands one hop later on clean slots.
    do_reset();
    send_frame(100, 100, 1'b0, 50, 1'b0);
    send_frame(100, 100, 1'b0, 256, 1'b1);
    send_frame(100, 200, 1'b0, 256, 1'b0);
    repeat (3) idle_b();

    // Reset after overlap sums were stored: next frame must see none of them.
    do_reset();
    send_frame(100, 100, 1'b0, 200, 1'b0);
    do_reset();
    send_frame(100, 100, 1'b0, 256, 1'b0);
    repeat (3) idle_b();

    // Small instance: x[n] = n then x[n] = 10 + n.
    do_reset();
    for (int n = 0; n < 8; n++) begin
      drv_s(n == 0, n);
      if (n < 4) q_s.push_back('{n, cyc});
    end
    for (int n = 0; n < 8; n++) begin
      drv_s(n == 0, 10 + n);
      if (n < 4) q_s.push_back('{sm_exp[n], cyc});
    end
    @(posedge clk);
    #1;
    if_s.frame_start_i  = 1'b0;
    if_s.sample_valid_i = 1'b0;

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("big outputs missing", q_b.size(), 0);
    check("small outputs missing", q_s.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
